// File: rtl/bcd_muldiv_seq_if.sv
// bcd_muldiv_seq_if: request/result/adder-mux bundle between control FSM, sequencer and shared BCD adder
interface bcd_muldiv_seq_if #(parameter int DIGIT_NUM = 8);
  logic start, op, a_sign, b_sign;
  logic busy, done, result_sign, flag_ov, flag_div0;
  logic alu_sub, alu_borrow;
  logic [4*DIGIT_NUM-1:0] a, b, result;
  logic [4*DIGIT_NUM+3:0] alu_a, alu_b, alu_res;
  modport master (
    output start, op, a, a_sign, b, b_sign, alu_res, alu_borrow,
    input busy, done, result, result_sign, flag_ov, flag_div0, alu_a, alu_b, alu_sub
  );
  modport slave (
    input start, op, a, a_sign, b, b_sign, alu_res, alu_borrow,
    output busy, done, result, result_sign, flag_ov, flag_div0, alu_a, alu_b, alu_sub
  );
endinterface

// File: rtl/bcd_muldiv_seq.sv
// bcd_muldiv_seq: multi-cycle sign-magnitude BCD multiply/divide time-sharing one external BCD add/sub unit
module bcd_muldiv_seq #(parameter int DIGIT_NUM = 8) (
  input logic clock,
  input logic reset,
  bcd_muldiv_seq_if.slave bus
);
  localparam int W = 4*DIGIT_NUM;
  localparam int IW = DIGIT_NUM > 1 ? $clog2(DIGIT_NUM) : 1;
  typedef enum logic [2:0] {IDLE, MUL_SHIFT, MUL_ADD, DIV_SHIFT, DIV_SUB, FINISH} state_t;
  state_t state_q, state_d;
  logic [W+3:0] acc_q, acc_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, quot_q, quot_d, res_q, res_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d, qd_q, qd_d, a_dig, b_dig;
  logic as_q, as_d, bs_q, bs_d, op_q, op_d, ov_q, ov_d, dz_q, dz_d;
  logic busy_q, busy_d, done_q, done_d, rs_q, rs_d, last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      a_q <= '0;
      b_q <= '0;
      quot_q <= '0;
      res_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      qd_q <= '0;
      {as_q, bs_q, op_q, ov_q, dz_q, busy_q, done_q, rs_q} <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      a_q <= a_d;
      b_q <= b_d;
      quot_q <= quot_d;
      res_q <= res_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      qd_q <= qd_d;
      {as_q, bs_q, op_q, ov_q, dz_q, busy_q, done_q, rs_q} <=
        {as_d, bs_d, op_d, ov_d, dz_d, busy_d, done_d, rs_d};
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    a_d = a_q;
    b_d = b_q;
    quot_d = quot_q;
    res_d = res_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    qd_d = qd_q;
    {as_d, bs_d, op_d, ov_d, dz_d, rs_d} = {as_q, bs_q, op_q, ov_q, dz_q, rs_q};
    busy_d = state_q != IDLE || bus.start;
    done_d = 1'b0;
    bus.alu_a = '0;
    bus.alu_b = '0;
    bus.alu_sub = 1'b0;
    a_dig = a_q[{idx_q, 2'b00} +: 4];
    b_dig = b_q[{idx_q, 2'b00} +: 4];
    last = idx_q == '0;
    case (state_q)
      IDLE: if (bus.start) begin
        a_d = bus.a;
        b_d = bus.b;
        as_d = bus.a_sign;
        bs_d = bus.b_sign;
        op_d = bus.op;
        acc_d = '0;
        quot_d = '0;
        idx_d = IW'(DIGIT_NUM-1);
        ov_d = 1'b0;
        dz_d = bus.op && bus.b == '0;
        state_d = dz_d ? FINISH : bus.op ? DIV_SHIFT : MUL_SHIFT;
      end
      MUL_SHIFT: begin
        acc_d = acc_q << 4;
        cnt_d = b_dig;
        // the digit moving into the guard position means the product no longer fits
        if (acc_q[W-1 -: 4] != 4'd0) begin
          ov_d = 1'b1;
          state_d = FINISH;
        end else if (b_dig != 4'd0) state_d = MUL_ADD;
        else begin
          idx_d = idx_q - 1'b1;
          state_d = last ? FINISH : MUL_SHIFT;
        end
      end
      MUL_ADD: begin
        bus.alu_a = acc_q;
        bus.alu_b = {4'd0, a_q};
        acc_d = bus.alu_res;
        cnt_d = cnt_q - 1'b1;
        if (bus.alu_res[W+3 -: 4] != 4'd0) begin
          ov_d = 1'b1;
          state_d = FINISH;
        end else if (cnt_q == 4'd1) begin
          idx_d = idx_q - 1'b1;
          state_d = last ? FINISH : MUL_SHIFT;
        end
      end
      DIV_SHIFT: begin
        acc_d = {acc_q[W-1:0], a_dig};
        qd_d = 4'd0;
        state_d = DIV_SUB;
      end
      DIV_SUB: begin
        bus.alu_a = acc_q;
        bus.alu_b = {4'd0, b_q};
        bus.alu_sub = 1'b1;
        if (!bus.alu_borrow) begin
          acc_d = bus.alu_res;
          qd_d = qd_q + 1'b1;
        end else begin
          quot_d = {quot_q[W-5:0], qd_q};
          idx_d = idx_q - 1'b1;
          state_d = last ? FINISH : DIV_SHIFT;
        end
      end
      FINISH: begin
        done_d = 1'b1;
        res_d = (ov_q || dz_q) ? '0 : op_q ? quot_q : acc_q[W-1:0];
        rs_d = (as_q ^ bs_q) && res_d != '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.result = res_q;
  assign bus.result_sign = rs_q;
  assign bus.flag_ov = ov_q;
  assign bus.flag_div0 = dz_q;
endmodule

// File: tb/tb_bcd_muldiv_seq.sv
// tb_bcd_muldiv_seq: directed vectors against a behavioural BCD adder, checking results, flags, latency and adder traffic
module tb_bcd_muldiv_seq;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0, n_bad = 0;
  int n_add = 0, n_sub = 0, n_nz = 0, n_done = 0;
  int s_add, s_sub, s_nz, lat, s_done;
  longint unsigned sa, sb;

  bcd_muldiv_seq_if #(.DIGIT_NUM(8)) bus ();
  bcd_muldiv_seq #(.DIGIT_NUM(8)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  function automatic longint unsigned b2i(input logic [35:0] v);
    longint unsigned r = 0;
    for (int k = 8; k >= 0; k--) r = r*10 + longint'(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [35:0] i2b(input longint unsigned x);
    logic [35:0] r;
    for (int k = 0; k < 9; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always_comb begin
    sa = b2i(bus.alu_a);
    sb = b2i(bus.alu_b);
    bus.alu_borrow = bus.alu_sub && sa < sb;
    bus.alu_res = i2b(bus.alu_sub ? (sa < sb ? sa + 64'd1000000000 - sb : sa - sb) : sa + sb);
  end

  always @(negedge clock) begin
    if (bus.alu_sub) n_sub++;
    else if (bus.alu_b != '0) n_add++;
    if (bus.alu_a != '0 || bus.alu_b != '0 || bus.alu_sub) n_nz++;
    if (bus.done) n_done++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // poke>0 raises a bogus divide-by-zero start that many cycles into the operation
  task automatic go(input logic op, input logic [31:0] a, input logic as, input logic [31:0] b,
                    input logic bs, input int poke);
    @(negedge clock);
    bus.op = op;
    bus.a = a;
    bus.a_sign = as;
    bus.b = b;
    bus.b_sign = bs;
    bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
    s_add = n_add;
    s_sub = n_sub;
    s_nz = n_nz;
    lat = 0;
    while (!bus.done && lat < 300) begin
      @(posedge clock);
      #1 lat++;
      bus.start = poke > 0 && lat == poke;
      if (bus.start) begin
        bus.op = 1'b1;
        bus.b = '0;
      end
    end
  endtask

  task automatic verify(input string tag, input int lat_e, input logic [31:0] res_e,
                        input logic rs_e, input logic ov_e, input logic dz_e);
    check({tag, "_lat"}, 64'(lat), 64'(lat_e));
    check({tag, "_res"}, 64'(bus.result), 64'(res_e));
    check({tag, "_sign"}, 64'(bus.result_sign), 64'(rs_e));
    check({tag, "_ov"}, 64'(bus.flag_ov), 64'(ov_e));
    check({tag, "_div0"}, 64'(bus.flag_div0), 64'(dz_e));
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.a_sign = 1'b0;
    bus.b_sign = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_res", 64'(bus.result), 64'd0);
    check("rst_flags", 64'({bus.flag_ov, bus.flag_div0, bus.result_sign}), 64'd0);
    check("rst_alu", 64'({bus.alu_a, bus.alu_b, bus.alu_sub} != '0), 64'd0);
    @(negedge clock) reset = 1'b0;

    go(1'b0, 32'h12, 1'b0, 32'h34, 1'b1, 0);
    verify("mul12x34", 16, 32'h408, 1'b1, 1'b0, 1'b0);
    check("mul12x34_adds", 64'(n_add - s_add), 64'd7);
    check("mul12x34_subs", 64'(n_sub - s_sub), 64'd0);

    go(1'b0, 32'h99999999, 1'b1, 32'h2, 1'b0, 0);
    verify("mulov", 11, 32'h0, 1'b0, 1'b1, 1'b0);
    check("mulov_adds", 64'(n_add - s_add), 64'd2);

    go(1'b0, 32'h3, 1'b0, 32'h3, 1'b0, 0);
    verify("mul3x3", 12, 32'h9, 1'b0, 1'b0, 1'b0);

    go(1'b1, 32'h100, 1'b1, 32'h7, 1'b0, 0);
    verify("div100_7", 22, 32'h14, 1'b1, 1'b0, 1'b0);
    check("div100_7_subs", 64'(n_sub - s_sub), 64'd13);

    go(1'b1, 32'h5, 1'b1, 32'h9, 1'b0, 0);
    verify("div5_9", 17, 32'h0, 1'b0, 1'b0, 1'b0);

    go(1'b1, 32'h123, 1'b1, 32'h0, 1'b0, 0);
    verify("div0", 1, 32'h0, 1'b0, 1'b0, 1'b1);
    check("div0_alu", 64'(n_nz - s_nz), 64'd0);

    go(1'b0, 32'h3, 1'b0, 32'h4, 1'b0, 3);
    verify("mulpoke", 13, 32'h12, 1'b0, 1'b0, 1'b0);

    go(1'b0, 32'h0, 1'b1, 32'h6, 1'b0, 0);
    verify("mul0x6", 15, 32'h0, 1'b0, 1'b0, 1'b0);
    check("mul0x6_alu", 64'(n_nz - s_nz), 64'd0);

    @(negedge clock);
    bus.op = 1'b1;
    bus.a = 32'h100;
    bus.b = 32'h7;
    bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    s_done = n_done;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_alu", 64'({bus.alu_a, bus.alu_b, bus.alu_sub} != '0), 64'd0);
    @(negedge clock) reset = 1'b0;
    repeat (30) @(posedge clock);
    #1;
    check("abort_nodone", 64'(n_done - s_done), 64'd0);
    check("abort_idle", 64'(bus.busy), 64'd0);

    go(1'b0, 32'h12, 1'b0, 32'h34, 1'b1, 0);
    verify("after_abort", 16, 32'h408, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bcd_muldiv_seq.md
Name: bcd_muldiv_seq

Overview:
Multi-cycle sequencer that runs sign-magnitude BCD multiply and divide by time-sharing one combinational BCD add/sub unit.
- Multiply uses shift-and-repeated-add.
- Divide uses restoring shift-and-repeated-subtract.
- Sits between the calculator control FSM, which issues start/op/operands, and the shared BCD adder, whose operand mux it drives.
- The control FSM uses it for MUL_OP and DIV_OP; the adder path alone handles SUM/SUB.

Parameters:
DIGIT_NUM, 8, number of BCD digits per operand and result.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high; clears all state.
start  input  1  request; sampled only in IDLE.
op  input  1  0 = multiply, 1 = divide.
a  input  4*DIGIT_NUM  operand A magnitude (dividend), BCD.
a_sign  input  1  1 = negative.
b  input  4*DIGIT_NUM  operand B magnitude (divisor), BCD.
b_sign  input  1  1 = negative.
busy  output  1  high from the cycle after start is accepted until FINISH, inclusive.
done  output  1  one-cycle pulse; result and flags valid.
result  output  4*DIGIT_NUM  BCD magnitude; product, or truncated quotient.
result_sign  output  1  sign of result.
flag_ov  output  1  product exceeded DIGIT_NUM digits.
flag_div0  output  1  divisor was zero.
alu_a  output  4*(DIGIT_NUM+1)  adder operand A.
alu_b  output  4*(DIGIT_NUM+1)  adder operand B.
alu_sub  output  1  0 = A+B, 1 = A-B.
alu_res  input  4*(DIGIT_NUM+1)  adder result, combinational, same cycle.
alu_borrow  input  1  high when A-B < 0 (alu_sub=1 only).

Behaviour:
- Reset values: busy, done, flags, result, result_sign and all alu_* outputs = 0; state = IDLE. Reset mid-operation aborts immediately; no done is issued.
- States: IDLE, MUL_SHIFT, MUL_ADD, DIV_SHIFT, DIV_SUB, FINISH.
- IDLE:
  - On start=1, latch a, b, signs and op.
  - Clear acc (DIGIT_NUM+1 digits), quotient and digit index i (starts at the MSD).
  - If op=1 and b==0: go to FINISH with flag_div0=1, result=0.
  - Otherwise go to MUL_SHIFT (op=0) or DIV_SHIFT (op=1).
  - start while not IDLE is ignored.
- MUL_SHIFT:
  - acc <= acc<<4; cnt <= b digit i.
  - If the shifted-out top digit is nonzero: flag_ov=1 and go to FINISH.
  - Otherwise go to MUL_ADD if cnt≠0; if cnt==0, go to the next digit's MUL_SHIFT, or to FINISH after digit 0.
- MUL_ADD:
  - Drive alu_a=acc, alu_b=zero-extended a, alu_sub=0; acc <= alu_res; cnt--.
  - If alu_res top digit (digit DIGIT_NUM) ≠ 0: flag_ov=1 and go to FINISH.
  - When cnt reaches 0, advance the digit as in MUL_SHIFT.
- DIV_SHIFT: acc <= (acc<<4) | a digit i; qd <= 0; go to DIV_SUB. No overflow is possible, because acc < b before the shift and acc is DIGIT_NUM+1 digits wide.
- DIV_SUB:
  - Drive alu_a=acc, alu_b=zero-extended b, alu_sub=1.
  - alu_borrow=0: acc <= alu_res; qd++; stay in DIV_SUB.
  - alu_borrow=1: quotient <= (quotient<<4)|qd; next digit's DIV_SHIFT, or FINISH after digit 0.
  - The remainder is discarded.
- Cycle accounting: one ALU step per cycle; the ALU is combinational, so each step takes exactly one clock.
- FINISH (one cycle), then IDLE:
  - done=1, busy=1.
  - result <= acc[low DIGIT_NUM digits] (mul) or quotient (div); on overflow or div0, result=0.
  - result_sign = a_sign^b_sign, forced to 0 if result==0.
  - result and flags hold until the next accepted start, which clears the flags.
- Latency, measured from the edge that samples start to done=1:
  - Multiply: DIGIT_NUM + Σ(b digits) + 1 clocks.
  - Divide: 2*DIGIT_NUM + Σ(quotient digits) + 1 clocks.
  - Div0: 1 clock.
  - Early overflow exit shortens the multiply latency.
- In IDLE and FINISH, alu_* outputs = 0.

Test Plan:
- DIGIT_NUM=8, mul a=12 (+), b=34 (−) -> done 16 cycles after start; result=00000408, result_sign=1, flags 0.
- Mul a=99999999, b=2 -> flag_ov=1, result=0, done asserted; a following mul 3×3 clears flag_ov and gives 9.
- Div a=100, b=7 -> result=14, done 22 cycles after start; div a=5, b=9 -> result=0, result_sign=0 even with a_sign=1.
- Div b=0 -> done 1 cycle after start; flag_div0=1, result=0; a start pulse asserted during busy of the next operation is ignored.
- Mul a=0 (−), b=6 (+) -> result=0, result_sign=0; check the alu_a/alu_b/alu_sub trace matches six adds of 0 with no spurious cycles.
- Assert reset mid-divide -> busy and done drop immediately, no done pulse; the next start runs correctly from IDLE.
